// File: rtl/ibex_irq_event_unit_pkg.sv
// Shared definitions for the interrupt event unit: ID width and request FSM encoding.
package ibex_irq_event_unit_pkg;

    localparam int unsigned IRQ_ID_W = 5;
    localparam int unsigned HOLD_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } irq_state_e;

endpackage

// File: rtl/ibex_irq_event_unit_if.sv
// Request/acknowledge link between the interrupt event unit (master) and the core (slave).
interface ibex_irq_event_unit_if;
    import ibex_irq_event_unit_pkg::*;

    logic                irq;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                irq_ack;
    logic [IRQ_ID_W-1:0] irq_ack_id;
    logic                ack_err;

    modport master (
        output irq,
        output irq_id,
        output ack_err,
        input  irq_ack,
        input  irq_ack_id
    );

    modport slave (
        input  irq,
        input  irq_id,
        input  ack_err,
        output irq_ack,
        output irq_ack_id
    );

endinterface

// File: rtl/ibex_irq_event_unit_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module ibex_irq_prio_enc
    import ibex_irq_event_unit_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic [NUM_IRQ-1:0]  vec_i,
    output logic                valid_o,
    output logic [IRQ_ID_W-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (vec_i[i] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ibex_irq_event_unit.sv
// Interrupt source unit: per-line pending/enable state, lowest-index arbitration and a
// request/ack FSM with a post-ack holdoff window, driving the core's irq/irq_id inputs.
module ibex_irq_event_unit
    import ibex_irq_event_unit_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 32,
    parameter logic [31:0] LEVEL_MASK = 32'h0,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq_src_i,
    input  logic [NUM_IRQ-1:0]    sw_set_i,
    input  logic                  cfg_we_i,
    input  logic [NUM_IRQ-1:0]    cfg_wdata_i,
    output logic [NUM_IRQ-1:0]    enable_o,
    output logic [NUM_IRQ-1:0]    pending_o,
    ibex_irq_event_unit_if.master irq_bus
);

    localparam logic [NUM_IRQ-1:0]    LevelBits = LEVEL_MASK[NUM_IRQ-1:0];
    localparam logic [HOLD_CNT_W-1:0] HoldLoad  = HOLD_CNT_W'(HOLDOFF - 1);

    irq_state_e            state_q, state_d;
    logic                  irq_q, irq_d;
    logic [IRQ_ID_W-1:0]   irq_id_q, irq_id_d;
    logic                  ack_err_q, ack_err_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [NUM_IRQ-1:0]    enable_q, enable_d;
    logic [NUM_IRQ-1:0]    pend_q, pend_d;
    logic [NUM_IRQ-1:0]    prev_q, prev_d;

    logic [NUM_IRQ-1:0]    eff_pend;
    logic [NUM_IRQ-1:0]    cand;
    logic                  cand_valid;
    logic [IRQ_ID_W-1:0]   cand_idx;
    logic                  ack_fire;
    logic [NUM_IRQ-1:0]    ack_clr;
    logic [NUM_IRQ-1:0]    edge_set;

    // Level lines bypass the pending flops entirely; their input is the pending state.
    assign eff_pend = (pend_q & ~LevelBits) | (irq_src_i & LevelBits);
    assign cand     = eff_pend & enable_q;

    ibex_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .vec_i   (cand),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    assign ack_fire = (state_q == ST_REQ) && irq_bus.irq_ack;

    // One-hot clear; ack IDs at or above NUM_IRQ match no line and clear nothing.
    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_bus.irq_ack_id == IRQ_ID_W'(i)) begin
                ack_clr[i] = ack_fire;
            end
        end
    end

    assign edge_set = ((irq_src_i & ~prev_q) | sw_set_i) & ~LevelBits;

    always_comb begin
        prev_d   = irq_src_i;
        pend_d   = ((pend_q & ~ack_clr) | edge_set) & ~LevelBits;
        enable_d = cfg_we_i ? cfg_wdata_i : enable_q;
    end

    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        irq_id_d   = irq_id_q;
        hold_cnt_d = hold_cnt_q;
        ack_err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (cand_valid) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = cand_idx;
                end
            end
            ST_REQ: begin
                // No retraction: the request and its ID only change via an ack.
                irq_d = 1'b1;
                if (irq_bus.irq_ack) begin
                    state_d    = ST_HOLD;
                    irq_d      = 1'b0;
                    hold_cnt_d = HoldLoad;
                    ack_err_d  = (irq_bus.irq_ack_id != irq_id_q);
                end
            end
            ST_HOLD: begin
                irq_d = 1'b0;
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            ack_err_q  <= 1'b0;
            hold_cnt_q <= '0;
            enable_q   <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
            ack_err_q  <= ack_err_d;
            hold_cnt_q <= hold_cnt_d;
            enable_q   <= enable_d;
            pend_q     <= pend_d;
            prev_q     <= prev_d;
        end
    end

    assign enable_o        = enable_q;
    assign pending_o       = eff_pend;
    assign irq_bus.irq     = irq_q;
    assign irq_bus.irq_id  = irq_id_q;
    assign irq_bus.ack_err = ack_err_q;

endmodule
